// File: rtl/secded_codec.sv
// 64-bit SECDED (72,64) encoder and decoder.
// Codeword layout: [63:0] data, [70:64] Hamming check bits, [71] overall parity.
module secded_codec (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] R_DATA,
  output logic [71:0] E_DATA,
  input  logic [71:0] C_DATA,
  output logic [71:0] D_DATA,
  output logic        ERR,
  output logic        S_ERR,
  output logic        D_ERR
);

  // Each set data bit contributes its Hamming position to the check vector.
  function automatic logic [6:0] check_bits(input logic [63:0] d);
    logic [6:0] c;
    logic [5:0] j;
    c = '0;
    j = '0;
    for (int p = 3; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[j]) c = c ^ 7'(p);
        j = j + 6'd1;
      end
    end
    return c;
  endfunction

  // Map a syndrome to the codeword bit it names; zero selects bit 71.
  function automatic logic [71:0] flip_mask(input logic [6:0] s);
    logic [71:0] m;
    logic [5:0]  j;
    logic [2:0]  k;
    m = '0;
    j = '0;
    k = '0;
    if (s == 7'd0) m[71] = 1'b1;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) == 0) begin
        if (s == 7'(p)) m[{4'b1000, k}] = 1'b1;
        k = k + 3'd1;
      end else begin
        if (s == 7'(p)) m[{1'b0, j}] = 1'b1;
        j = j + 6'd1;
      end
    end
    return m;
  endfunction

  logic [6:0]  enc_c;
  logic [71:0] enc_cw;
  logic [6:0]  syn;
  logic        par;
  logic        single;
  logic        double;
  logic [71:0] dec_cw;

  always_comb begin
    enc_c  = check_bits(R_DATA);
    enc_cw = {^{enc_c, R_DATA}, enc_c, R_DATA};
  end

  always_comb begin
    syn    = check_bits(C_DATA[63:0]) ^ C_DATA[70:64];
    par    = ^C_DATA;
    single = par && (syn < 7'd72);
    double = par ? (syn >= 7'd72) : (syn != 7'd0);
    dec_cw = C_DATA;
    if (single) dec_cw = C_DATA ^ flip_mask(syn);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      E_DATA <= '0;
      D_DATA <= '0;
      ERR    <= 1'b0;
      S_ERR  <= 1'b0;
      D_ERR  <= 1'b0;
    end else begin
      E_DATA <= enc_cw;
      D_DATA <= dec_cw;
      ERR    <= single | double;
      S_ERR  <= single;
      D_ERR  <= double;
    end
  end

endmodule

// File: tb/tb_secded_codec.sv
// Self-checking bench for secded_codec.
// Expected results come from a position-table model and the injected flip count.
module tb_secded_codec;

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] R_DATA;
  logic [71:0] E_DATA;
  logic [71:0] C_DATA;
  logic [71:0] D_DATA;
  logic        ERR;
  logic        S_ERR;
  logic        D_ERR;

  secded_codec dut (
    .CLK    (CLK),
    .RST    (RST),
    .R_DATA (R_DATA),
    .E_DATA (E_DATA),
    .C_DATA (C_DATA),
    .D_DATA (D_DATA),
    .ERR    (ERR),
    .S_ERR  (S_ERR),
    .D_ERR  (D_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [71:0] e;
    logic [71:0] d;
    logic        err;
    logic        s;
    logic        dd;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Place data at non-power-of-two positions, then each check bit is the
  // parity of every position whose index has that bit set.
  function automatic logic [71:0] model_enc(input logic [63:0] d);
    logic [71:0] h;
    logic [6:0]  c;
    logic [71:0] cw;
    int i;
    h = '0;
    i = 0;
    for (int pos = 1; pos < 72; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        h[pos] = d[i];
        i++;
      end
    end
    for (int k = 0; k < 7; k++) begin
      c[k] = 1'b0;
      for (int pos = 1; pos < 72; pos++)
        if (((pos >> k) & 1) == 1) c[k] = c[k] ^ h[pos];
    end
    cw = {1'b0, c, d};
    cw[71] = ^cw[70:0];
    return cw;
  endfunction

  task automatic chk72(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk72("e_data", E_DATA, x.e);
        chk72("d_data", D_DATA, x.d);
        chk1("err", ERR, x.err);
        chk1("s_err", S_ERR, x.s);
        chk1("d_err", D_ERR, x.dd);
      end
    end
  end

  // cw is the clean codeword; mask holds the injected bit flips (0..2 bits).
  task automatic drive(input bit rst, input logic [63:0] r,
                       input logic [71:0] cw, input logic [71:0] mask);
    exp_t x;
    int n;
    @(negedge CLK);
    RST    = rst;
    R_DATA = r;
    C_DATA = cw ^ mask;
    n = $countones(mask);
    if (rst) begin
      x = '{72'h0, 72'h0, 1'b0, 1'b0, 1'b0};
    end else begin
      x.e   = model_enc(r);
      x.d   = (n == 2) ? (cw ^ mask) : cw;
      x.s   = (n == 1);
      x.dd  = (n == 2);
      x.err = (n != 0);
    end
    q.push_back(x);
  endtask

  logic [63:0] vals [3];
  logic [71:0] mask;
  logic [63:0] v;
  int a;
  int b;
  int w;

  initial begin
    RST    = 1'b1;
    R_DATA = '0;
    C_DATA = '0;

    chk72("pin_zero", model_enc(64'h0), 72'h00_0000000000000000);
    chk72("pin_bit0", model_enc(64'h1), 72'h83_0000000000000001);
    chk72("pin_bit1", model_enc(64'h2), 72'h85_0000000000000002);
    chk72("pin_bit63", model_enc(64'h8000000000000000),
          72'hC7_8000000000000000);

    drive(1'b1, 64'h0, 72'h0, 72'h0);
    drive(1'b1, 64'h0, 72'h0, 72'h0);

    drive(1'b0, 64'h1, 72'h83_0000000000000001, 72'h0);
    drive(1'b0, 64'h8000000000000000, 72'hC7_8000000000000000, 72'h0);

    vals[0] = 64'hDEADBEEFCAFECAFE;
    vals[1] = 64'hCAFECAFEDEADBEEF;
    vals[2] = 64'h1212343456567878;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, vals[i], model_enc(vals[i]), 72'h0);
      drive(1'b0, vals[i], model_enc(vals[i]), 72'h000000000000100000);
      drive(1'b0, vals[i], model_enc(vals[i]), 72'h000110000000000000);
      drive(1'b0, vals[i], model_enc(vals[i]), 72'h01_0000000000000000);
      drive(1'b0, vals[i], model_enc(vals[i]), 72'h40_0000000000000000);
      drive(1'b0, vals[i], model_enc(vals[i]), 72'h80_0000000000000000);
    end

    drive(1'b0, vals[1], model_enc(vals[1]), 72'h0);
    drive(1'b1, vals[1], model_enc(vals[1]), 72'h000000000000100000);
    drive(1'b0, vals[0], model_enc(vals[0]), 72'h0);

    for (int bit_i = 0; bit_i < 72; bit_i++) begin
      v = {$urandom, $urandom};
      mask = '0;
      mask[bit_i] = 1'b1;
      drive(1'b0, v, model_enc(v), mask);
    end

    for (int t = 0; t < 40; t++) begin
      v = {$urandom, $urandom};
      a = $urandom_range(71, 0);
      b = $urandom_range(70, 0);
      if (b >= a) b++;
      mask = '0;
      mask[a] = 1'b1;
      mask[b] = 1'b1;
      drive(1'b0, v, model_enc(v), mask);
    end

    w = 0;
    while (q.size() != 0 && w < 10) begin
      @(posedge CLK);
      #2;
      w++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results pending, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
